// File: rtl/ofdm_frame_sequencer.sv
// Frame-level sequencer in front of guard_insert: latches per-frame config, gates the sample
// stream, counts preamble/payload segments and emits frame-end tlast. Optional stall watchdog: OFDM_SEQ_WATCHDOG_EN.
module ofdm_frame_sequencer #(
  parameter int unsigned G_PREAMBLE_LEN = 4096,
  parameter int unsigned G_NSYM_W       = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [G_NSYM_W-1:0] i_num_symbols,
  input  logic [13:0]         i_nfft,
  input  logic [11:0]         i_cp_len,
  input  logic [31:0]         i_guard_cycles,
  input  logic [31:0]         s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic [13:0]         o_nfft,
  output logic [11:0]         o_cp_len,
  output logic [31:0]         o_guard_cycles,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_aborted,
`ifdef OFDM_SEQ_WATCHDOG_EN
  output logic                o_timeout,
`endif
  output logic [G_NSYM_W-1:0] o_sym_idx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRE,
    ST_SYM,
    ST_DONE
  } state_t;

  localparam logic [16:0] PRE_BASE = 17'(G_PREAMBLE_LEN);
  localparam logic [G_NSYM_W-1:0] SYM_ONE = G_NSYM_W'(1);

  state_t state, state_nxt;

  logic [13:0]         nfft_q;
  logic [11:0]         cp_len_q;
  logic [31:0]         guard_q;
  logic [G_NSYM_W-1:0] num_sym_q;
  logic [G_NSYM_W-1:0] sym_idx_q;
  logic [16:0]         pre_len_q;
  logic [16:0]         sym_len_q;
  logic [16:0]         beat_cnt_q;
  logic                aborted_q;

  logic        pass;
  logic        active;
  logic        beat;
  logic        seg_end;
  logic        last_seg;
  logic        at_final;
  logic        abort_req;
  logic        abort_take;
  logic        start_take;
  logic        wd_trip;
  logic [16:0] cp_add;

  // Decode of the current position within the frame.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pass       = 1'b0;
    active     = 1'b0;
    seg_end    = 1'b0;
    last_seg   = 1'b0;
    cp_add     = 17'd0;
    pass       = (state == ST_PRE) || (state == ST_SYM);
    active     = pass || (state == ST_LOAD);
    beat       = pass && s_axis_tvalid && m_axis_tready;
    start_take = (state == ST_IDLE) && i_start;
    abort_req  = i_abort || wd_trip;
    abort_take = active && abort_req;
    if (cp_len_q != 12'd0) cp_add = 17'(cp_len_q) + 17'd1;
    if (state == ST_PRE) begin
      seg_end  = (beat_cnt_q == pre_len_q - 17'd1);
      last_seg = (num_sym_q == '0);
    end else if (state == ST_SYM) begin
      seg_end  = (beat_cnt_q == sym_len_q - 17'd1);
      last_seg = (sym_idx_q == num_sym_q - SYM_ONE);
    end
    at_final = pass && seg_end && last_seg;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_PRE;
      ST_PRE: begin
        if (beat && seg_end) state_nxt = last_seg ? ST_DONE : ST_SYM;
      end
      ST_SYM: begin
        if (beat && seg_end && last_seg) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_take) state_nxt = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      nfft_q     <= '0;
      cp_len_q   <= '0;
      guard_q    <= '0;
      num_sym_q  <= '0;
      sym_idx_q  <= '0;
      pre_len_q  <= '0;
      sym_len_q  <= '0;
      beat_cnt_q <= '0;
      aborted_q  <= 1'b0;
    end else begin
      aborted_q <= abort_take;
      if (start_take) begin
        nfft_q     <= i_nfft;
        cp_len_q   <= i_cp_len;
        guard_q    <= i_guard_cycles;
        num_sym_q  <= i_num_symbols;
        sym_idx_q  <= '0;
        beat_cnt_q <= '0;
      end
      if (state == ST_LOAD) begin
        pre_len_q <= PRE_BASE + cp_add;
        sym_len_q <= 17'(nfft_q) + 17'd1 + cp_add;
      end
      if (abort_take || state == ST_DONE) begin
        beat_cnt_q <= '0;
        sym_idx_q  <= '0;
      end else if (beat) begin
        if (seg_end) begin
          beat_cnt_q <= '0;
          // Preamble exit and the final symbol leave the index untouched.
          if (state == ST_SYM && !last_seg) sym_idx_q <= sym_idx_q + SYM_ONE;
        end else begin
          beat_cnt_q <= beat_cnt_q + 17'd1;
        end
      end
    end
  end

`ifdef OFDM_SEQ_WATCHDOG_EN
  logic [23:0] stall_cnt_q;
  logic        timeout_q;

  assign wd_trip   = pass && (stall_cnt_q == 24'hFF_FFFF);
  assign o_timeout = timeout_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (!pass || beat) stall_cnt_q <= '0;
      else               stall_cnt_q <= stall_cnt_q + 24'd1;
      if (start_take)   timeout_q <= 1'b0;
      else if (wd_trip) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
`endif

  // Abort suppresses tlast even when it coincides with the final beat.
  assign m_axis_tdata   = pass ? s_axis_tdata : 32'd0;
  assign m_axis_tvalid  = pass && s_axis_tvalid;
  assign s_axis_tready  = pass && m_axis_tready;
  assign m_axis_tlast   = at_final && s_axis_tvalid && !abort_req;

  assign o_nfft         = nfft_q;
  assign o_cp_len       = cp_len_q;
  assign o_guard_cycles = guard_q;
  assign o_busy         = active;
  assign o_done         = (state == ST_DONE);
  assign o_aborted      = aborted_q;
  assign o_sym_idx      = sym_idx_q;

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Scoreboard bench for ofdm_frame_sequencer: stimulus pushes expected beats and end events,
// an independent monitor pops and compares on every downstream handshake and status pulse.
module tb_ofdm_frame_sequencer;

  localparam int PRE_LEN = 8;
  localparam int NSW     = 8;

  logic           aclk;
  logic           aresetn;
  logic           i_start;
  logic           i_abort;
  logic [NSW-1:0] i_num_symbols;
  logic [13:0]    i_nfft;
  logic [11:0]    i_cp_len;
  logic [31:0]    i_guard_cycles;
  logic [31:0]    s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [31:0]    m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic           m_axis_tready;
  logic [13:0]    o_nfft;
  logic [11:0]    o_cp_len;
  logic [31:0]    o_guard_cycles;
  logic           o_busy;
  logic           o_done;
  logic           o_aborted;
  logic [NSW-1:0] o_sym_idx;
`ifdef OFDM_SEQ_WATCHDOG_EN
  logic           o_timeout;
`endif

  ofdm_frame_sequencer #(
    .G_PREAMBLE_LEN(PRE_LEN),
    .G_NSYM_W      (NSW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_num_symbols (i_num_symbols),
    .i_nfft        (i_nfft),
    .i_cp_len      (i_cp_len),
    .i_guard_cycles(i_guard_cycles),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .o_nfft        (o_nfft),
    .o_cp_len      (o_cp_len),
    .o_guard_cycles(o_guard_cycles),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_aborted     (o_aborted),
`ifdef OFDM_SEQ_WATCHDOG_EN
    .o_timeout     (o_timeout),
`endif
    .o_sym_idx     (o_sym_idx)
  );

  typedef struct {
    logic [31:0]    data;
    logic           last;
    logic [NSW-1:0] idx;
    logic [13:0]    nfft;
  } beat_t;

  beat_t       exp_q[$];
  bit          ev_q[$];   // 0 = done, 1 = aborted
  int          n_cmp;
  int          n_err;
  int          beats_seen;
  int          events_seen;
  longint      cyc;
  longint      last_cyc;
  bit          stall_mode;
  bit          hs_q;
  logic [31:0] src_data;
  logic [31:0] exp_data;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Upstream source: sequential data words, optional random stalls, AXI-legal valid hold.
  initial begin
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    src_data      = 32'hA000_0000;
    s_axis_tdata  = src_data;
    forever begin
      @(negedge aclk);
      hs_q = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      if (hs_q) src_data = src_data + 32'd1;
      s_axis_tdata = src_data;
      if (!s_axis_tvalid || hs_q)
        s_axis_tvalid = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expectations on each downstream beat and on each done/abort pulse.
  initial begin
    beat_t e;
    bit    ev;
    forever begin
      @(negedge aclk);
      cyc++;
      if (aresetn) begin
        if (m_axis_tvalid && m_axis_tready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got data %0h with no beat expected", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_axis_tdata, e.data);
            check("beat_tlast", m_axis_tlast, e.last);
            check("beat_sym_idx", o_sym_idx, e.idx);
            check("beat_o_nfft", o_nfft, e.nfft);
          end
          if (m_axis_tlast) last_cyc = cyc;
        end
        if (o_done || o_aborted) begin
          events_seen++;
          if (ev_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got done=%0b aborted=%0b with none expected", o_done, o_aborted);
          end else begin
            ev = ev_q.pop_front();
            check("event_aborted", o_aborted, ev);
            check("event_done", o_done, !ev);
            check("busy_after_end", o_busy, 0);
            if (!ev) check("done_latency", cyc - last_cyc, 1);
          end
        end
      end
    end
  end

  task automatic run_frame(input logic [13:0] nfft, input logic [11:0] cp, input logic [31:0] guard,
                           input logic [NSW-1:0] nsym, input int exp_beats,
                           input int abort_at, input int restart_at);
    int    cp_add, pre, sym, total, n, base, ev0;
    beat_t e;
    cp_add = (cp == 0) ? 0 : int'(cp) + 1;
    pre    = PRE_LEN + cp_add;
    sym    = int'(nfft) + 1 + cp_add;
    total  = pre + int'(nsym) * sym;
    n      = (abort_at > 0) ? abort_at : total;
    for (int i = 1; i <= n; i++) begin
      e.data = exp_data;
      e.last = (i == total) && (abort_at == 0);
      e.idx  = (i <= pre) ? '0 : NSW'((i - pre - 1) / sym);
      e.nfft = nfft;
      exp_q.push_back(e);
      exp_data = exp_data + 32'd1;
    end
    ev_q.push_back(abort_at > 0);
    base = beats_seen;
    ev0  = events_seen;
    @(posedge aclk);
    #1;
    i_nfft         = nfft;
    i_cp_len       = cp;
    i_guard_cycles = guard;
    i_num_symbols  = nsym;
    i_start        = 1'b1;
    @(posedge aclk);
    #1;
    i_start = 1'b0;
    check("load_busy", o_busy, 1);
    check("load_o_nfft", o_nfft, nfft);
    check("load_o_cp_len", o_cp_len, cp);
    check("load_o_guard", o_guard_cycles, guard);
    if (restart_at > 0) begin
      repeat (restart_at) @(posedge aclk);
      #1;
      i_nfft  = 14'd63;
      i_start = 1'b1;
      @(posedge aclk);
      #1;
      i_start = 1'b0;
    end
    if (abort_at > 0) begin
      for (int k = 0; k < 3000 && (beats_seen - base) < abort_at - 1; k++) begin
        @(negedge aclk);
        #1;
      end
      @(posedge aclk);
      #1;
      i_abort = 1'b1;
      @(posedge aclk);
      #1;
      i_abort = 1'b0;
    end
    for (int k = 0; k < 3000 && events_seen == ev0; k++) begin
      @(negedge aclk);
      #1;
    end
    check("frame_end_seen", events_seen - ev0, 1);
    check("frame_beats", beats_seen - base, exp_beats);
    check("held_o_nfft", o_nfft, nfft);
    repeat (3) @(posedge aclk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    beats_seen     = 0;
    events_seen    = 0;
    cyc            = 0;
    last_cyc       = 0;
    stall_mode     = 1'b0;
    exp_data       = 32'hA000_0000;
    aresetn        = 1'b0;
    i_start        = 1'b0;
    i_abort        = 1'b0;
    i_num_symbols  = '0;
    i_nfft         = '0;
    i_cp_len       = '0;
    i_guard_cycles = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_aborted", o_aborted, 0);
    check("rst_o_nfft", o_nfft, 0);
    check("rst_sym_idx", o_sym_idx, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_s_tready", s_axis_tready, 0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // 13 + 37 + 37 beats
    run_frame(14'd31, 12'd4, 32'd10, 8'd2, 87, 0, 0);
    // no CP: 8 + 32 + 32 beats
    run_frame(14'd31, 12'd0, 32'd10, 8'd2, 72, 0, 0);
    // preamble only
    run_frame(14'd31, 12'd4, 32'd10, 8'd0, 13, 0, 0);
    stall_mode = 1'b1;
    run_frame(14'd31, 12'd4, 32'd10, 8'd2, 87, 0, 0);
    stall_mode = 1'b0;
    // second start mid-frame must be ignored
    run_frame(14'd31, 12'd4, 32'd10, 8'd2, 87, 0, 20);
    // abort on beat 40, then a clean frame
    run_frame(14'd31, 12'd4, 32'd10, 8'd2, 40, 40, 0);
    check("post_abort_busy", o_busy, 0);
    run_frame(14'd31, 12'd4, 32'd10, 8'd2, 87, 0, 0);

    check("leftover_beats", exp_q.size(), 0);
    check("leftover_events", ev_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
